// File: rtl/my_pc_stack.sv
// my_pc_stack: program counter with an integrated return-address stack.
// Each cycle exactly one operation is performed, chosen by fixed priority
// reset > call > ret > load > branch > inc > hold. A call on a full stack or
// a ret on an empty stack is swallowed: the PC holds, lower-priority
// operations are suppressed, and a sticky error flag is raised.
module my_pc_stack #(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [WIDTH-1:0]           in,
    input  logic                       load,
    input  logic                       branch,
    input  logic                       inc,
    input  logic                       call,
    input  logic                       ret,
    output logic [WIDTH-1:0]           out,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       empty,
    output logic                       full,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int DW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [DW-1:0]    DEPTH_MAX = DW'(DEPTH);
    localparam logic [DW-1:0]    DONE      = DW'(1);

    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] next_out;
    logic [WIDTH-1:0] ret_addr;
    logic [DW-1:0]    depth_m1;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             push;
    logic             pop;
    logic             call_err;
    logic             ret_err;

    assign empty    = (depth == '0);
    assign full     = (depth == DEPTH_MAX);

    // The push slot is the current depth; the top entry sits one below it.
    // Both are only used when the stack is not full / not empty respectively,
    // so truncating to the array index width is safe.
    assign depth_m1 = depth - DONE;
    assign wr_idx   = depth[AW-1:0];
    assign rd_idx   = depth_m1[AW-1:0];
    assign ret_addr = out + ONE;

    // Priority decode of stack operations and their error cases.
    assign push     = call && !full;
    assign call_err = call && full;
    assign pop      = !call && ret && !empty;
    assign ret_err  = !call && ret && empty;

    // Next PC selection by fixed priority; error cases fall through to hold.
    always_comb begin
        next_out = out;
        if (call) begin
            if (!full) next_out = in;
        end else if (ret) begin
            if (!empty) next_out = stack[rd_idx];
        end else if (load) begin
            next_out = in;
        end else if (branch) begin
            next_out = out + in;   // two's-complement offset, wraps mod 2^WIDTH
        end else if (inc) begin
            next_out = out + ONE;
        end
    end

    // PC, stack depth and sticky error flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out       <= RESET_VAL;
            depth     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            out <= next_out;
            if (push)          depth <= depth + DONE;
            else if (pop)      depth <= depth_m1;
            if (call_err)      overflow  <= 1'b1;
            if (ret_err)       underflow <= 1'b1;
        end
    end

    // Stack storage has no reset; entries above depth are never read.
    always_ff @(posedge clk) begin
        if (!reset && push) stack[wr_idx] <= ret_addr;
    end

endmodule

// File: tb/tb_my_pc_stack.sv
// Self-checking bench for my_pc_stack: directed scenarios plus a randomized
// run, all checked against a queue-based reference model.
module tb_my_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] RV = 16'h0000;

    logic             clk = 1'b0;
    logic             reset, load, branch, inc, call, ret;
    logic [WIDTH-1:0] in;
    logic [WIDTH-1:0] out;
    logic [DW-1:0]    depth;
    logic             empty, full, overflow, underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic [WIDTH-1:0] m_out = RV;
    logic [WIDTH-1:0] m_stk[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    my_pc_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(RV)) dut (
        .clk(clk), .reset(reset), .in(in), .load(load), .branch(branch),
        .inc(inc), .call(call), .ret(ret), .out(out), .depth(depth),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Model one cycle from the architectural rules.
    task automatic model_update();
        if (reset) begin
            m_out = RV; m_stk.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        end else if (call) begin
            if (m_stk.size() == DEPTH) m_ovf = 1'b1;
            else begin m_stk.push_back(m_out + 16'd1); m_out = in; end
        end else if (ret) begin
            if (m_stk.size() == 0) m_unf = 1'b1;
            else m_out = m_stk.pop_back();
        end else if (load)   m_out = in;
        else if (branch)     m_out = m_out + in;
        else if (inc)        m_out = m_out + 16'd1;
    endtask

    function automatic logic [WIDTH+DW+3:0] model_vec();
        return {m_out, DW'(m_stk.size()), m_stk.size() == 0,
                m_stk.size() == DEPTH, m_ovf, m_unf};
    endfunction

    // Drive one cycle of controls, advance the model, sample #1 after the edge.
    task automatic apply(input logic rst, input logic c, input logic r,
                         input logic l, input logic b, input logic i,
                         input logic [WIDTH-1:0] d);
        reset = rst; call = c; ret = r; load = l; branch = b; inc = i; in = d;
        model_update();
        @(posedge clk); #1;
        reset = 0; call = 0; ret = 0; load = 0; branch = 0; inc = 0;
    endtask

    task automatic test_reset();
        apply(1, 0, 0, 0, 0, 0, 16'h1234);
        n_tests++;
        if ({out, depth, empty, full, overflow, underflow} !== {RV, DW'(0), 4'b1000}) begin
            n_fail++;
            $display("FAIL reset_state: got out=%h depth=%0d e=%b f=%b o=%b u=%b, want out=%h depth=0 e=1 f=0 o=0 u=0",
                     out, depth, empty, full, overflow, underflow, RV);
        end
    endtask

    task automatic test_inc_wrap();
        for (int k = 1; k <= 3; k++) begin
            apply(0, 0, 0, 0, 0, 1, '0);
            n_tests++;
            if (out !== WIDTH'(k)) begin
                n_fail++; $display("FAIL inc_%0d: got %h want %h", k, out, WIDTH'(k));
            end
        end
        apply(0, 0, 0, 1, 0, 0, 16'hFFFF);
        n_tests++;
        if (out !== 16'hFFFF) begin n_fail++; $display("FAIL load_ffff: got %h want ffff", out); end
        apply(0, 0, 0, 0, 0, 1, '0);
        n_tests++;
        if (out !== 16'h0000) begin n_fail++; $display("FAIL inc_wrap: got %h want 0000", out); end
    endtask

    task automatic test_branch();
        apply(0, 0, 0, 1, 0, 0, 16'h0010);
        apply(0, 0, 0, 0, 1, 0, 16'hFFFC);
        n_tests++;
        if (out !== 16'h000C) begin n_fail++; $display("FAIL branch_neg: got %h want 000c", out); end
        apply(0, 0, 0, 0, 1, 0, 16'h0004);
        n_tests++;
        if (out !== 16'h0010) begin n_fail++; $display("FAIL branch_pos: got %h want 0010", out); end
    endtask

    task automatic test_nested_calls();
        apply(0, 0, 0, 1, 0, 0, 16'h0100);
        apply(0, 1, 0, 0, 0, 0, 16'h0200);
        apply(0, 1, 0, 0, 0, 0, 16'h0300);
        n_tests++;
        if (depth !== DW'(2) || out !== 16'h0300) begin
            n_fail++; $display("FAIL nested_call: got out=%h depth=%0d want out=0300 depth=2", out, depth);
        end
        apply(0, 0, 1, 0, 0, 0, '0);
        n_tests++;
        if (out !== 16'h0201 || depth !== DW'(1)) begin
            n_fail++; $display("FAIL nested_ret1: got out=%h depth=%0d want out=0201 depth=1", out, depth);
        end
        apply(0, 0, 1, 0, 0, 0, '0);
        n_tests++;
        if (out !== 16'h0101 || depth !== DW'(0) || empty !== 1'b1) begin
            n_fail++; $display("FAIL nested_ret2: got out=%h depth=%0d empty=%b want out=0101 depth=0 empty=1",
                               out, depth, empty);
        end
    endtask

    task automatic test_overflow();
        logic [WIDTH-1:0] held;
        for (int k = 0; k < DEPTH; k++) apply(0, 1, 0, 0, 0, 0, WIDTH'($urandom));
        n_tests++;
        if (full !== 1'b1 || depth !== DW'(DEPTH)) begin
            n_fail++; $display("FAIL fill: got full=%b depth=%0d want full=1 depth=%0d", full, depth, DEPTH);
        end
        held = out;
        apply(0, 1, 0, 1, 0, 1, 16'h0ABC);
        n_tests++;
        if (out !== held || depth !== DW'(DEPTH) || overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_call: got out=%h depth=%0d ovf=%b want out=%h depth=%0d ovf=1",
                               out, depth, overflow, held, DEPTH);
        end
        for (int k = 0; k < DEPTH; k++) begin
            apply(0, 0, 1, 0, 0, 0, '0);
            n_tests++;
            if (out !== m_out || overflow !== 1'b1 || depth !== DW'(m_stk.size())) begin
                n_fail++; $display("FAIL lifo_ret_%0d: got out=%h depth=%0d ovf=%b want out=%h depth=%0d ovf=1",
                                   k, out, depth, overflow, m_out, m_stk.size());
            end
        end
    endtask

    task automatic test_underflow_priority();
        logic [WIDTH-1:0] held;
        held = out;
        apply(0, 0, 1, 1, 1, 1, 16'h7777);
        n_tests++;
        if (out !== held || underflow !== 1'b1 || depth !== DW'(0)) begin
            n_fail++; $display("FAIL underflow_ret: got out=%h unf=%b depth=%0d want out=%h unf=1 depth=0",
                               out, underflow, depth, held);
        end
        apply(0, 0, 0, 1, 0, 0, 16'h0010);
        apply(0, 1, 1, 1, 0, 1, 16'h0050);
        n_tests++;
        if (out !== 16'h0050 || depth !== DW'(1)) begin
            n_fail++; $display("FAIL priority_call: got out=%h depth=%0d want out=0050 depth=1", out, depth);
        end
        apply(0, 0, 1, 0, 0, 0, '0);
        n_tests++;
        if (out !== 16'h0011 || depth !== DW'(0)) begin
            n_fail++; $display("FAIL priority_top: got out=%h depth=%0d want out=0011 depth=0", out, depth);
        end
    endtask

    task automatic test_reset_mid();
        apply(1, 0, 0, 0, 0, 0, '0);
        for (int k = 0; k < DEPTH + 1; k++) apply(0, 1, 0, 0, 0, 0, WIDTH'(16'h0400 + k));
        for (int k = 0; k < DEPTH - 3; k++) apply(0, 0, 1, 0, 0, 0, '0);
        n_tests++;
        if (depth !== DW'(3) || overflow !== 1'b1) begin
            n_fail++; $display("FAIL mid_setup: got depth=%0d ovf=%b want depth=3 ovf=1", depth, overflow);
        end
        apply(1, 1, 0, 0, 0, 0, 16'h0999);
        n_tests++;
        if (out !== RV || depth !== DW'(0) || empty !== 1'b1 || overflow !== 1'b0) begin
            n_fail++; $display("FAIL reset_mid: got out=%h depth=%0d empty=%b ovf=%b want out=%h depth=0 empty=1 ovf=0",
                               out, depth, empty, overflow, RV);
        end
        apply(0, 0, 1, 0, 0, 0, '0);
        n_tests++;
        if (out !== RV || underflow !== 1'b1) begin
            n_fail++; $display("FAIL reset_no_push: got out=%h unf=%b want out=%h unf=1", out, underflow, RV);
        end
    endtask

    task automatic test_random();
        logic [WIDTH+DW+3:0] exp_v;
        for (int n = 0; n < 3000; n++) begin
            apply(($urandom % 64) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
                  ($urandom % 5) == 0, ($urandom % 4) == 0, ($urandom % 2) == 0,
                  WIDTH'($urandom));
            exp_v = model_vec();
            n_tests++;
            if ({out, depth, empty, full, overflow, underflow} !== exp_v) begin
                n_fail++;
                $display("FAIL random_%0d: got out=%h depth=%0d e=%b f=%b o=%b u=%b want vec=%h",
                         n, out, depth, empty, full, overflow, underflow, exp_v);
            end
        end
    endtask

    initial begin
        reset = 1; call = 0; ret = 0; load = 0; branch = 0; inc = 0; in = '0;
        @(negedge clk);
        test_reset();
        test_inc_wrap();
        test_branch();
        test_nested_calls();
        test_overflow();
        test_underflow_priority();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
